// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write bus of the instruction memory loader.
// The loader takes the master modport; the stream source / memory side takes slave.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_address,
        output wr_data
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_address,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream MSB-first into 32-bit words
// and writes them to consecutive word offsets of the instruction memory image.
module imem_loader #(
    parameter logic [23:0] BASE_ADDRESS = 24'd0,
    parameter int unsigned MAX_WORDS    = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [6:0]   word_count,
    output logic         busy,
    output logic         done,
    output logic         error,
    imem_loader_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  offset_q, offset_d;
    logic [6:0]  count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        error_q, error_d;
    logic        illegal_count;
    logic        accept;
    logic        last_word;

    assign illegal_count = (word_count == 7'd0) || ({25'd0, word_count} > MAX_WORDS);
    assign accept        = (state_q == LOAD) && bus.byte_valid;
    assign last_word     = ({1'b0, offset_q} == (count_q - 7'd1));

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (illegal_count) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d    = 1'b0;
                        count_d    = word_count;
                        offset_d   = 6'd0;
                        byte_idx_d = 2'd0;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    data_d     = {data_q[23:0], bus.byte_in};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Capture the finished word now so the write bus stays stable until the next word.
                    if (byte_idx_q == 2'd3) begin
                        wdata_d = {data_q[23:0], bus.byte_in};
                        addr_d  = {BASE_ADDRESS, offset_q, 2'b00};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    offset_d = offset_q + 6'd1;
                    state_d  = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            offset_q   <= 6'd0;
            count_q    <= 7'd0;
            byte_idx_q <= 2'd0;
            data_q     <= 32'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
        end
    end

    assign bus.byte_ready = (state_q == LOAD);
    assign bus.wr_en      = (state_q == WRITE);
    assign bus.wr_address = addr_q;
    assign bus.wr_data    = wdata_q;
    assign busy           = (state_q == LOAD) || (state_q == WRITE);
    assign done           = (state_q == DONE);
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios, write scoreboard,
// plus hand sequences for start-while-busy and reset mid-load.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] word_count = 7'd0;
    logic       busy, done, error;

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDRESS (24'd0),
        .MAX_WORDS    (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [6:0] count;
        bit         gaps;
        bit         exp_err;
        int         pat;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_writes = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic prev_wr_en = 1'b0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pattern 1 is the movi/nop/mov program; nop is taken as the all-zero word.
    function automatic logic [31:0] word_of(input int pat, input int idx);
        logic [7:0] b;
        case (pat)
            1: begin
                if (idx == 0)      word_of = 32'h1804_000A;
                else if (idx == 5) word_of = 32'h9084_3000;
                else               word_of = 32'h0000_0000;
            end
            2: begin
                b = 8'(4 * idx);
                word_of = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            end
            3: word_of = 32'hA55A_0F00 ^ (32'(idx) * 32'h0101_0101);
            default: word_of = 32'hDEAD_BEEF ^ 32'(idx);
        endcase
    endfunction

    // Scoreboard side: every observed write is popped against the expectation queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.wr_en === 1'b1) begin
                n_writes++;
                check("byte_ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
                check("wr_en_single_cycle", {31'd0, prev_wr_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                             bus.wr_address, bus.wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_address", bus.wr_address, mon_e.addr);
                    check("wr_data", bus.wr_data, mon_e.data);
                end
            end
            prev_wr_en = bus.wr_en;
        end else begin
            prev_wr_en = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        if (gaps) begin
            for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) begin
                bus.byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = bus.byte_ready;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL byte_accept_timeout: byte_ready got 0, expected 1");
        end
    endtask

    task automatic send_word(input int pat, input int idx, input bit gaps);
        wr_t         e;
        logic [31:0] w;
        w      = word_of(pat, idx);
        e.addr = {24'd0, 6'(idx), 2'b00};
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[31 - 8 * k -: 8], gaps);
    endtask

    task automatic do_start(input logic [6:0] n);
        start      = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int wbase;
        vecs[0] = '{count: 7'd1,   gaps: 1'b0, exp_err: 1'b0, pat: 1};
        vecs[1] = '{count: 7'd6,   gaps: 1'b0, exp_err: 1'b0, pat: 1};
        vecs[2] = '{count: 7'd3,   gaps: 1'b1, exp_err: 1'b0, pat: 1};
        vecs[3] = '{count: 7'd0,   gaps: 1'b0, exp_err: 1'b1, pat: 0};
        vecs[4] = '{count: 7'd65,  gaps: 1'b0, exp_err: 1'b1, pat: 0};
        vecs[5] = '{count: 7'd2,   gaps: 1'b0, exp_err: 1'b0, pat: 3};
        vecs[6] = '{count: 7'd64,  gaps: 1'b0, exp_err: 1'b0, pat: 2};
        vecs[7] = '{count: 7'd127, gaps: 1'b0, exp_err: 1'b1, pat: 0};
        vecs[8] = '{count: 7'd3,   gaps: 1'b1, exp_err: 1'b0, pat: 3};

        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;

        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("reset_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("reset_wr_address", bus.wr_address, 32'd0);
        check("reset_wr_data", bus.wr_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            wbase = n_writes;
            do_start(vecs[v].count);
            if (vecs[v].exp_err) begin
                @(negedge clk);
                check("err_error", {31'd0, error}, 32'd1);
                check("err_busy", {31'd0, busy}, 32'd0);
                check("err_done", {31'd0, done}, 32'd0);
                check("err_no_write", 32'(n_writes - wbase), 32'd0);
            end else begin
                check("load_busy", {31'd0, busy}, 32'd1);
                check("load_error_cleared", {31'd0, error}, 32'd0);
                for (int w = 0; w < int'(vecs[v].count); w++) send_word(vecs[v].pat, w, vecs[v].gaps);
                @(negedge clk);
                check("done_next_cycle", {31'd0, done}, 32'd1);
                check("done_busy", {31'd0, busy}, 32'd0);
                check("done_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
                check("write_count", 32'(n_writes - wbase), 32'(vecs[v].count));
                check("queue_drained", 32'(exp_q.size()), 32'd0);
            end
        end

        // start while busy must not reload the count or flag an error
        wbase = n_writes;
        do_start(7'd2);
        send_word(4, 0, 1'b0);
        do_start(7'd0);
        check("busy_start_error", {31'd0, error}, 32'd0);
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        send_word(4, 1, 1'b0);
        @(negedge clk);
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_writes", 32'(n_writes - wbase), 32'd2);

        // reset after two bytes of word 3 discards the partial word
        do_start(7'd4);
        for (int w = 0; w < 3; w++) send_word(3, w, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("async_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("async_rst_wr_address", bus.wr_address, 32'd0);
        check("async_rst_wr_data", bus.wr_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wbase = n_writes;
        do_start(7'd1);
        send_word(4, 0, 1'b0);
        @(negedge clk);
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_writes", 32'(n_writes - wbase), 32'd1);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
